// File: rtl/led_matrix_scan_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// led_matrix_scan_ctrl : COLS x ROWS framebuffer, column scan with PWM + scroll
// Rev 1.0
// ----------------------------------------------------------------------------
module led_matrix_scan_ctrl #(
  parameter int COLS          = 32,
  parameter int ROWS          = 8,
  parameter int DWELL_W       = 4,
  parameter int SCROLL_FRAMES = 4,
  localparam int CW           = $clog2(COLS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [CW-1:0]      wr_col,
  input  logic [ROWS-1:0]    wr_data,
  input  logic [DWELL_W-1:0] brightness,
  input  logic               scroll_en,
  input  logic               scroll_dir,
  output logic [CW-1:0]      col_idx,
  output logic [ROWS-1:0]    row_data,
  output logic               col_en,
  output logic               frame_start
);

  localparam int FW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
  localparam logic [CW:0]   COLS_C     = (CW+1)'(COLS);
  localparam logic [CW-1:0] LAST_COL   = CW'(COLS - 1);
  localparam logic [FW-1:0] LAST_FRAME = FW'(SCROLL_FRAMES - 1);

  logic [ROWS-1:0]    fb_q [COLS];
  logic [ROWS-1:0]    fb_d [COLS];
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [CW-1:0]      col_q, col_d;
  logic [CW-1:0]      offset_q, offset_d;
  logic [FW-1:0]      frame_cnt_q, frame_cnt_d;
  logic [ROWS-1:0]    row_q, row_d;
  logic [DWELL_W-1:0] bright_q, bright_d;
  logic               frame_start_q, frame_start_d;

  logic               dwell_wrap;
  logic               frame_wrap;
  logic [CW:0]        sum;
  logic [CW-1:0]      rd_idx;

  always_comb begin
    dwell_wrap    = &dwell_q;
    frame_wrap    = dwell_wrap && (col_q == LAST_COL);
    dwell_d       = dwell_q + DWELL_W'(1);
    col_d         = col_q;
    offset_d      = offset_q;
    frame_cnt_d   = frame_cnt_q;
    row_d         = row_q;
    bright_d      = bright_q;
    fb_d          = fb_q;
    frame_start_d = frame_wrap;

    if (dwell_wrap) begin
      col_d = (col_q == LAST_COL) ? '0 : col_q + CW'(1);
    end

    // Single conditional subtract keeps the rotation correct for non-power-of-two COLS
    sum    = {1'b0, col_q} + {1'b0, offset_q};
    rd_idx = (sum >= COLS_C) ? CW'(sum - COLS_C) : CW'(sum);

    if (dwell_q == '0) begin
      row_d    = fb_q[rd_idx];
      bright_d = brightness;
    end

    if (wr_en && ({1'b0, wr_col} < COLS_C)) begin
      fb_d[wr_col] = wr_data;
    end

    // Offset only moves on the frame boundary so a frame never tears
    if (!scroll_en) begin
      frame_cnt_d = '0;
    end else if (frame_wrap) begin
      if (frame_cnt_q == LAST_FRAME) begin
        frame_cnt_d = '0;
        if (!scroll_dir) begin
          offset_d = (offset_q == LAST_COL) ? '0 : offset_q + CW'(1);
        end else begin
          offset_d = (offset_q == '0) ? LAST_COL : offset_q - CW'(1);
        end
      end else begin
        frame_cnt_d = frame_cnt_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fb_q          <= '{default: '0};
      dwell_q       <= '0;
      col_q         <= '0;
      offset_q      <= '0;
      frame_cnt_q   <= '0;
      row_q         <= '0;
      bright_q      <= '0;
      frame_start_q <= 1'b0;
    end else begin
      fb_q          <= fb_d;
      dwell_q       <= dwell_d;
      col_q         <= col_d;
      offset_q      <= offset_d;
      frame_cnt_q   <= frame_cnt_d;
      row_q         <= row_d;
      bright_q      <= bright_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign col_idx     = col_q;
  assign row_data    = row_q;
  assign col_en      = (dwell_q != '0) && (dwell_q <= bright_q);
  assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_led_matrix_scan_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_led_matrix_scan_ctrl : directed bench, 32-column and 24-column instances
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_led_matrix_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [4:0] wr_col = '0;
  logic [7:0] wr_data = '0;
  logic [3:0] brightness = 4'd15;
  logic       scroll_en = 1'b0;
  logic       scroll_dir = 1'b0;

  logic [4:0] col_idx_a, col_idx_b;
  logic [7:0] row_data_a, row_data_b;
  logic       col_en_a, col_en_b;
  logic       frame_start_a, frame_start_b;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  led_matrix_scan_ctrl #(.COLS(32)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_col(wr_col), .wr_data(wr_data),
    .brightness(brightness), .scroll_en(scroll_en), .scroll_dir(scroll_dir),
    .col_idx(col_idx_a), .row_data(row_data_a), .col_en(col_en_a),
    .frame_start(frame_start_a)
  );

  led_matrix_scan_ctrl #(.COLS(24)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_col(wr_col), .wr_data(wr_data),
    .brightness(brightness), .scroll_en(scroll_en), .scroll_dir(scroll_dir),
    .col_idx(col_idx_b), .row_data(row_data_b), .col_en(col_en_b),
    .frame_start(frame_start_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  // After return the DUTs sit at col 0 / dwell 0 with cyc = 0
  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst   = 1'b0;
    wr_en = 1'b0;
    cyc   = 0;
  endtask

  task automatic write_col(input logic [4:0] c, input logic [7:0] d);
    wr_en = 1'b1; wr_col = c; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1; wr_en = 1'b1; wr_col = 5'd3; wr_data = 8'hFF;
    repeat (3) tick();
    n_cmp++;
    if ({col_idx_a, row_data_a, col_en_a, frame_start_a} !== 15'd0) begin
      n_bad++;
      $display("FAIL reset_outs_a: got idx=%0d row=%h en=%b fs=%b want all 0",
               col_idx_a, row_data_a, col_en_a, frame_start_a);
    end
    n_cmp++;
    if ({col_idx_b, row_data_b, col_en_b, frame_start_b} !== 15'd0) begin
      n_bad++;
      $display("FAIL reset_outs_b: got idx=%0d row=%h en=%b fs=%b want all 0",
               col_idx_b, row_data_b, col_en_b, frame_start_b);
    end
    rst = 1'b0; wr_en = 1'b0; cyc = 0;
    bad = 0;
    for (int k = 0; k < 512; k++) begin
      tick();
      if (row_data_a !== 8'h00 || row_data_b !== 8'h00) bad++;
      if (col_idx_a !== 5'((cyc / 16) % 32)) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL reset_frame_zero: %0d bad cycles, want 0", bad);
    end
  endtask

  task automatic test_basic();
    int en_cnt, row_bad, idx_bad, fs_bad;
    logic [7:0] exp_row;
    brightness = 4'd15; scroll_en = 1'b0;
    do_reset();
    write_col(5'd3, 8'hA5);
    en_cnt = 0; row_bad = 0; idx_bad = 0; fs_bad = 0;
    for (int k = 0; k < 512; k++) begin
      if (col_en_a) en_cnt++;
      if (col_en_a !== ((cyc % 16) != 0)) row_bad++;
      if ((cyc % 16) != 0) begin
        exp_row = (((cyc / 16) % 32) == 3) ? 8'hA5 : 8'h00;
        if (row_data_a !== exp_row) row_bad++;
      end
      if (col_idx_a !== 5'((cyc / 16) % 32)) idx_bad++;
      if (frame_start_a !== (cyc == 512)) fs_bad++;
      tick();
    end
    n_cmp++;
    if (en_cnt != 480) begin
      n_bad++; $display("FAIL basic_en_count: got %0d want 480", en_cnt);
    end
    n_cmp++;
    if (row_bad != 0) begin
      n_bad++; $display("FAIL basic_row_en: %0d bad cycles want 0", row_bad);
    end
    n_cmp++;
    if (idx_bad != 0) begin
      n_bad++; $display("FAIL basic_col_idx: %0d bad cycles want 0", idx_bad);
    end
    n_cmp++;
    if (fs_bad != 0) begin
      n_bad++; $display("FAIL basic_frame_start: %0d bad cycles want 0", fs_bad);
    end
    run_to(1024);
    n_cmp++;
    if (frame_start_a !== 1'b1 || col_idx_a !== 5'd0) begin
      n_bad++;
      $display("FAIL basic_fs_1024: got fs=%b idx=%0d want fs=1 idx=0", frame_start_a, col_idx_a);
    end
    run_to(1073);
    n_cmp++;
    if (row_data_a !== 8'hA5 || col_idx_a !== 5'd3 || col_en_a !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_col3: got row=%h idx=%0d en=%b want A5 3 1", row_data_a, col_idx_a, col_en_a);
    end
    run_to(1088);
    n_cmp++;
    if (row_data_a !== 8'hA5 || col_idx_a !== 5'd4 || col_en_a !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_blank_dwell0: got row=%h idx=%0d en=%b want A5 4 0", row_data_a, col_idx_a, col_en_a);
    end
  endtask

  task automatic test_pwm();
    int en_cnt;
    brightness = 4'd5;
    do_reset();
    en_cnt = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (col_en_a) en_cnt++;
      if (k == 4 && col_en_a !== 1'b1) en_cnt += 100;
      if (k == 5 && col_en_a !== 1'b0) en_cnt += 100;
    end
    n_cmp++;
    if (en_cnt != 5) begin
      n_bad++; $display("FAIL pwm_5_of_16: got %0d want 5", en_cnt);
    end
    run_to(20);
    brightness = 4'd0;
    tick();
    n_cmp++;
    if (col_en_a !== 1'b1) begin
      n_bad++; $display("FAIL pwm_midcol_hold: got %b want 1", col_en_a);
    end
    tick();
    n_cmp++;
    if (col_en_a !== 1'b0) begin
      n_bad++; $display("FAIL pwm_midcol_off: got %b want 0", col_en_a);
    end
    run_to(32);
    en_cnt = 0;
    while (cyc < 48) begin
      tick();
      if (cyc == 40) brightness = 4'd15;
      if (col_en_a) en_cnt++;
    end
    n_cmp++;
    if (en_cnt != 0) begin
      n_bad++; $display("FAIL pwm_zero_dark: got %0d want 0", en_cnt);
    end
    tick();
    n_cmp++;
    if (col_en_a !== 1'b1) begin
      n_bad++; $display("FAIL pwm_next_col: got %b want 1", col_en_a);
    end
  endtask

  task automatic test_scroll();
    brightness = 4'd15; scroll_en = 1'b1; scroll_dir = 1'b0;
    do_reset();
    write_col(5'd3, 8'hA5);
    run_to(1569);
    n_cmp++;
    if (col_idx_a !== 5'd2 || row_data_a !== 8'h00) begin
      n_bad++; $display("FAIL scrl_l_pre_col2: got idx=%0d row=%h want 2 00", col_idx_a, row_data_a);
    end
    run_to(1585);
    n_cmp++;
    if (col_idx_a !== 5'd3 || row_data_a !== 8'hA5) begin
      n_bad++; $display("FAIL scrl_l_pre_col3: got idx=%0d row=%h want 3 A5", col_idx_a, row_data_a);
    end
    run_to(2081);
    n_cmp++;
    if (col_idx_a !== 5'd2 || row_data_a !== 8'hA5) begin
      n_bad++; $display("FAIL scrl_l_col2: got idx=%0d row=%h want 2 A5", col_idx_a, row_data_a);
    end
    run_to(2097);
    n_cmp++;
    if (col_idx_a !== 5'd3 || row_data_a !== 8'h00) begin
      n_bad++; $display("FAIL scrl_l_col3: got idx=%0d row=%h want 3 00", col_idx_a, row_data_a);
    end

    scroll_dir = 1'b1;
    do_reset();
    write_col(5'd3, 8'hA5);
    run_to(2097);
    n_cmp++;
    if (col_idx_a !== 5'd3 || row_data_a !== 8'h00) begin
      n_bad++; $display("FAIL scrl_r_col3: got idx=%0d row=%h want 3 00", col_idx_a, row_data_a);
    end
    run_to(2113);
    n_cmp++;
    if (col_idx_a !== 5'd4 || row_data_a !== 8'hA5) begin
      n_bad++; $display("FAIL scrl_r_col4: got idx=%0d row=%h want 4 A5", col_idx_a, row_data_a);
    end
    scroll_en = 1'b0;
    run_to(4161);
    n_cmp++;
    if (col_idx_a !== 5'd4 || row_data_a !== 8'hA5) begin
      n_bad++; $display("FAIL scrl_hold: got idx=%0d row=%h want 4 A5", col_idx_a, row_data_a);
    end
  endtask

  task automatic test_nonpow2();
    int bad;
    logic [7:0] exp_row;
    brightness = 4'd15; scroll_en = 1'b0; scroll_dir = 1'b1;
    do_reset();
    write_col(5'd30, 8'hFF);
    write_col(5'd22, 8'h3C);
    bad = 0;
    while (cyc < 384) begin
      tick();
      if (col_idx_b !== 5'((cyc / 16) % 24)) bad++;
      if (frame_start_b !== (cyc == 384)) bad++;
      if ((cyc % 16) != 0) begin
        exp_row = (((cyc / 16) % 24) == 22) ? 8'h3C : 8'h00;
        if (row_data_b !== exp_row) bad++;
      end
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++; $display("FAIL np2_frame: %0d bad cycles want 0", bad);
    end
    n_cmp++;
    if (col_idx_b !== 5'd0 || frame_start_b !== 1'b1) begin
      n_bad++; $display("FAIL np2_wrap: got idx=%0d fs=%b want 0 1", col_idx_b, frame_start_b);
    end
    scroll_en = 1'b1;
    run_to(1920 + 353);
    n_cmp++;
    if (col_idx_b !== 5'd22 || row_data_b !== 8'h00) begin
      n_bad++; $display("FAIL np2_off23_col22: got idx=%0d row=%h want 22 00", col_idx_b, row_data_b);
    end
    run_to(1920 + 369);
    n_cmp++;
    if (col_idx_b !== 5'd23 || row_data_b !== 8'h3C) begin
      n_bad++; $display("FAIL np2_off23_col23: got idx=%0d row=%h want 23 3C", col_idx_b, row_data_b);
    end
    scroll_dir = 1'b0;
    run_to(3072 + 369);
    n_cmp++;
    if (col_idx_b !== 5'd23 || row_data_b !== 8'h3C) begin
      n_bad++; $display("FAIL np2_pre_wrap: got idx=%0d row=%h want 23 3C", col_idx_b, row_data_b);
    end
    run_to(3456 + 353);
    n_cmp++;
    if (col_idx_b !== 5'd22 || row_data_b !== 8'h3C) begin
      n_bad++; $display("FAIL np2_off0_col22: got idx=%0d row=%h want 22 3C", col_idx_b, row_data_b);
    end
    run_to(3456 + 369);
    n_cmp++;
    if (col_idx_b !== 5'd23 || row_data_b !== 8'h00) begin
      n_bad++; $display("FAIL np2_off0_col23: got idx=%0d row=%h want 23 00", col_idx_b, row_data_b);
    end
    scroll_en = 1'b0;
  endtask

  task automatic test_collision_reset();
    brightness = 4'd15; scroll_en = 1'b0;
    do_reset();
    write_col(5'd5, 8'h11);
    run_to(80);
    write_col(5'd5, 8'hFF);
    n_cmp++;
    if (col_idx_a !== 5'd5 || row_data_a !== 8'h11) begin
      n_bad++; $display("FAIL coll_old: got idx=%0d row=%h want 5 11", col_idx_a, row_data_a);
    end
    run_to(512 + 81);
    n_cmp++;
    if (row_data_a !== 8'hFF) begin
      n_bad++; $display("FAIL coll_new: got row=%h want FF", row_data_a);
    end
    run_to(512 + 17 * 16 + 9);
    n_cmp++;
    if (col_idx_a !== 5'd17 || col_en_a !== 1'b1) begin
      n_bad++; $display("FAIL midrst_pre: got idx=%0d en=%b want 17 1", col_idx_a, col_en_a);
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({col_idx_a, row_data_a, col_en_a, frame_start_a} !== 15'd0) begin
      n_bad++;
      $display("FAIL midrst_outs: got idx=%0d row=%h en=%b fs=%b want all 0",
               col_idx_a, row_data_a, col_en_a, frame_start_a);
    end
    rst = 1'b0; cyc = 0;
    tick();
    n_cmp++;
    if (col_idx_a !== 5'd0 || col_en_a !== 1'b1 || row_data_a !== 8'h00) begin
      n_bad++;
      $display("FAIL midrst_restart: got idx=%0d en=%b row=%h want 0 1 00", col_idx_a, col_en_a, row_data_a);
    end
    run_to(81);
    n_cmp++;
    if (col_idx_a !== 5'd5 || row_data_a !== 8'h00) begin
      n_bad++; $display("FAIL midrst_fb_clear: got idx=%0d row=%h want 5 00", col_idx_a, row_data_a);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pwm();
    test_scroll();
    test_nonpow2();
    test_collision_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/led_matrix_scan_ctrl.md
Name: led_matrix_scan_ctrl

Overview:
- Parametrised successor to the fixed 32x8 LED matrix driver.
- Holds a COLS x ROWS 1-bit framebuffer written one column per cycle.
- Scans it column by column with per-column dwell, a global PWM brightness and an optional hardware scroll (left/right, wrap-around).
- Sits between the tt_um top-level pin mapping and the column/row driver pins.

Parameters:
COLS, 32, number of matrix columns (2..64, need not be a power of two)
ROWS, 8, number of rows = bits per column word (1..16)
DWELL_W, 4, dwell counter width; each column is held for 2^DWELL_W cycles
SCROLL_FRAMES, 4, frames between scroll steps when scroll_en=1 (>=1)
CW, $clog2(COLS), column index width (derived, not overridden)

Ports:
clk  in  1  clock, all logic on the rising edge
rst  in  1  synchronous reset, active-high
wr_en  in  1  framebuffer write strobe
wr_col  in  CW  column address for write
wr_data  in  ROWS  column bit pattern, bit r = row r
brightness  in  DWELL_W  on-time per column in dwell cycles (0 = dark)
scroll_en  in  1  enable automatic scrolling
scroll_dir  in  1  0 = left (offset+1), 1 = right (offset-1)
col_idx  out  CW  physical column currently driven
row_data  out  ROWS  row drive pattern for col_idx
col_en  out  1  column drive enable (PWM / blanking)
frame_start  out  1  one-cycle pulse at start of each frame

Behaviour:
- Reset (rst=1 at clock edge):
  - framebuffer, col_cnt, dwell_cnt, offset, frame_cnt, row_data, bright_q and frame_start all cleared to 0.
  - col_idx=0 and col_en=0 throughout reset.
  - Reset mid-frame aborts the scan immediately; no partial state is kept.
- Dwell counter: dwell_cnt increments every cycle, wrapping 2^DWELL_W-1 -> 0. col_cnt increments on that wrap, wrapping COLS-1 -> 0. Frame length = COLS * 2^DWELL_W cycles (default 512).
- col_idx = col_cnt (registered).
- Load cycle (dwell_cnt==0): row_data <= fb[(col_cnt + offset) mod COLS] and bright_q <= brightness. Both are valid from dwell_cnt==1.
- col_en = (dwell_cnt != 0) && (dwell_cnt <= bright_q). This is combinational from registers only.
  - dwell 0 is always blanked, so row_data changes while blank.
  - Max on-time is 2^DWELL_W-1 cycles per column.
- Writes: on wr_en, fb[wr_col] <= wr_data.
  - wr_col >= COLS is ignored.
  - Read-before-write: a write to the column being loaded in the same cycle is seen on the next visit, not the current one.
  - Writes are accepted in any cycle and never stall.
- Scroll:
  - At the frame wrap (col_cnt==COLS-1 and dwell_cnt max), frame_cnt increments if scroll_en=1.
  - When frame_cnt reaches SCROLL_FRAMES-1 at the frame wrap, frame_cnt <= 0 and offset steps. dir=0 gives offset+1, wrapping COLS-1 -> 0. dir=1 gives offset-1, wrapping 0 -> COLS-1.
  - The new offset takes effect from column 0 of the next frame, so there is no mid-frame tearing.
  - scroll_en=0 holds offset and clears frame_cnt.
- Modulo: (col_cnt + offset) is computed in CW+1 bits. If the result is >= COLS, subtract COLS. Required for non-power-of-two COLS.
- frame_start: registered. It is set for exactly the cycle in which col_cnt==0 and dwell_cnt==0 following a frame wrap. The first frame after reset is not flagged.

Test Plan:
- Reset: hold rst 3 cycles with wr_en=1 -> col_idx=0, row_data=0, col_en=0, frame_start=0. After release, every column reads 0x00 for a full 512-cycle frame.
- Basic scan (defaults): write col 3 = 0xA5, brightness=15 -> row_data=0xA5 while col_idx=3 at dwell 1..15, col_en high 15 cycles per column. frame_start pulses every 512 cycles.
- PWM: brightness=5 -> col_en high at dwell 1..5 only (5/16). brightness=0 -> col_en never high. Change brightness mid-column -> takes effect next column.
- Scroll left: fb col 3 = 0xA5, scroll_en=1, dir=0 -> after 4 frame wraps offset=1 and col_idx=2 shows 0xA5. Scroll right from offset 0 -> offset=31, col_idx=4 shows 0xA5.
- Non-power-of-two, COLS=24: col_cnt wraps 23->0, frame = 384 cycles. Write wr_col=30 is ignored. Offset 23 scrolling left wraps to 0, and col_idx 23 shows fb col 22 at offset 23.
- Collision/reset: write 0xFF to col 5 on its load cycle -> current visit shows old data, next frame shows 0xFF. Assert rst at col 17 dwell 9 -> all outputs 0 next cycle, scan restarts at col 0.
